// File: rtl/alu_rs_scheduler_if.sv
// rtl/alu_rs_scheduler_if.sv - dispatch, CDB broadcast and ALU issue bus of the ALU reservation station
// master drives dispatch/CDB/control; slave is the reservation station.
interface alu_rs_scheduler_if #(
  parameter int ROB_ID_WIDTH = 4,
  parameter int OP_ID_WIDTH  = 6
);
  logic                    rdy;
  logic                    clear;
  logic                    DP_input_valid;
  logic [OP_ID_WIDTH-1:0]  DP_OP_ID;
  logic [31:0]             DP_inst_pc, DP_Vj, DP_Vk, DP_imm;
  logic [ROB_ID_WIDTH-1:0] DP_Qj, DP_Qk, DP_ROB_id;
  logic                    DP_Qj_busy, DP_Qk_busy;
  logic                    RS_full;
  logic                    ALU_CDB_valid, LSB_CDB_valid;
  logic [ROB_ID_WIDTH-1:0] ALU_CDB_ROB_id, LSB_CDB_ROB_id;
  logic [31:0]             ALU_CDB_value, LSB_CDB_value;
  logic                    ALU_input_valid;
  logic [OP_ID_WIDTH-1:0]  ALU_OP_ID;
  logic [31:0]             ALU_inst_pc, ALU_reg_rs1, ALU_reg_rs2, ALU_imm;
  logic [ROB_ID_WIDTH-1:0] ALU_ROB_id;

  modport master (
    output rdy, clear, DP_input_valid, DP_OP_ID, DP_inst_pc, DP_Vj, DP_Vk, DP_imm,
           DP_Qj, DP_Qk, DP_ROB_id, DP_Qj_busy, DP_Qk_busy,
           ALU_CDB_valid, LSB_CDB_valid, ALU_CDB_ROB_id, LSB_CDB_ROB_id,
           ALU_CDB_value, LSB_CDB_value,
    input  RS_full, ALU_input_valid, ALU_OP_ID, ALU_inst_pc, ALU_reg_rs1, ALU_reg_rs2,
           ALU_imm, ALU_ROB_id
  );

  modport slave (
    input  rdy, clear, DP_input_valid, DP_OP_ID, DP_inst_pc, DP_Vj, DP_Vk, DP_imm,
           DP_Qj, DP_Qk, DP_ROB_id, DP_Qj_busy, DP_Qk_busy,
           ALU_CDB_valid, LSB_CDB_valid, ALU_CDB_ROB_id, LSB_CDB_ROB_id,
           ALU_CDB_value, LSB_CDB_value,
    output RS_full, ALU_input_valid, ALU_OP_ID, ALU_inst_pc, ALU_reg_rs1, ALU_reg_rs2,
           ALU_imm, ALU_ROB_id
  );
endinterface

// File: rtl/alu_rs_scheduler.sv
// rtl/alu_rs_scheduler.sv - ALU reservation station: allocate, CDB wakeup, one issue per cycle
// Define RS_OLDEST_FIRST_EN for oldest-first select; default is lowest-index-ready select.
module alu_rs_scheduler #(
  parameter int RS_SIZE      = 16,
  parameter int ROB_ID_WIDTH = 4,
  parameter int OP_ID_WIDTH  = 6
) (
  input logic               clk,
  input logic               rst,
  alu_rs_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0]      busy, qj_busy, qk_busy;
  logic [OP_ID_WIDTH-1:0]  op  [RS_SIZE];
  logic [31:0]             pc  [RS_SIZE];
  logic [31:0]             vj  [RS_SIZE];
  logic [31:0]             vk  [RS_SIZE];
  logic [31:0]             imm [RS_SIZE];
  logic [ROB_ID_WIDTH-1:0] qj  [RS_SIZE];
  logic [ROB_ID_WIDTH-1:0] qk  [RS_SIZE];
  logic [ROB_ID_WIDTH-1:0] rob [RS_SIZE];
  logic [CNT_W-1:0]        occupancy;
`ifdef RS_OLDEST_FIRST_EN
  logic [CNT_W-1:0]        age [RS_SIZE];
  logic [CNT_W-1:0]        best_age;
`endif

  logic [RS_SIZE-1:0]      ready;
  logic                    issue, any_free, alloc;
  logic [IDX_W-1:0]        sel_idx, free_idx;

  logic                    alu_v, lsb_v;
  logic [ROB_ID_WIDTH-1:0] alu_tag, lsb_tag;
  logic [31:0]             alu_val, lsb_val;

  assign alu_v   = bus.ALU_CDB_valid;
  assign alu_tag = bus.ALU_CDB_ROB_id;
  assign alu_val = bus.ALU_CDB_value;
  assign lsb_v   = bus.LSB_CDB_valid;
  assign lsb_tag = bus.LSB_CDB_ROB_id;
  assign lsb_val = bus.LSB_CDB_value;

  // Returns {still_pending, value}; the ALU CDB wins if both broadcast the same tag.
  function automatic logic [32:0] snoop(input logic pend, input logic [ROB_ID_WIDTH-1:0] tag,
                                        input logic [31:0] val);
    if (pend && alu_v && alu_tag == tag) return {1'b0, alu_val};
    if (pend && lsb_v && lsb_tag == tag) return {1'b0, lsb_val};
    return {pend, val};
  endfunction

  assign ready       = busy & ~qj_busy & ~qk_busy;
  assign bus.RS_full = occupancy >= CNT_W'(RS_SIZE - 1);
  assign alloc       = bus.DP_input_valid & any_free & ~bus.clear;

  always_comb begin
    issue   = 1'b0;
    sel_idx = '0;
`ifdef RS_OLDEST_FIRST_EN
    best_age = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready[i] && (!issue || age[i] > best_age)) begin
        issue    = 1'b1;
        sel_idx  = IDX_W'(i);
        best_age = age[i];
      end
    end
`else
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue   = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
`endif
  end

  // Uses registered busy, so a slot issuing this cycle is not handed out until the next one.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy                <= '0;
      qj_busy             <= '0;
      qk_busy             <= '0;
      occupancy           <= '0;
      bus.ALU_input_valid <= 1'b0;
      bus.ALU_OP_ID       <= '0;
      bus.ALU_inst_pc     <= '0;
      bus.ALU_reg_rs1     <= '0;
      bus.ALU_reg_rs2     <= '0;
      bus.ALU_imm         <= '0;
      bus.ALU_ROB_id      <= '0;
    end else if (bus.rdy) begin
      if (bus.clear) begin
        busy                <= '0;
        occupancy           <= '0;
        bus.ALU_input_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i]) begin
            {qj_busy[i], vj[i]} <= snoop(qj_busy[i], qj[i], vj[i]);
            {qk_busy[i], vk[i]} <= snoop(qk_busy[i], qk[i], vk[i]);
`ifdef RS_OLDEST_FIRST_EN
            age[i] <= (age[i] == '1) ? age[i] : age[i] + 1'b1;
`endif
          end
        end
        bus.ALU_input_valid <= issue;
        if (issue) begin
          busy[sel_idx]   <= 1'b0;
          bus.ALU_OP_ID   <= op[sel_idx];
          bus.ALU_inst_pc <= pc[sel_idx];
          bus.ALU_reg_rs1 <= vj[sel_idx];
          bus.ALU_reg_rs2 <= vk[sel_idx];
          bus.ALU_imm     <= imm[sel_idx];
          bus.ALU_ROB_id  <= rob[sel_idx];
        end
        if (alloc) begin
          busy[free_idx] <= 1'b1;
          op[free_idx]   <= bus.DP_OP_ID;
          pc[free_idx]   <= bus.DP_inst_pc;
          imm[free_idx]  <= bus.DP_imm;
          rob[free_idx]  <= bus.DP_ROB_id;
          qj[free_idx]   <= bus.DP_Qj;
          qk[free_idx]   <= bus.DP_Qk;
          {qj_busy[free_idx], vj[free_idx]} <= snoop(bus.DP_Qj_busy, bus.DP_Qj, bus.DP_Vj);
          {qk_busy[free_idx], vk[free_idx]} <= snoop(bus.DP_Qk_busy, bus.DP_Qk, bus.DP_Vk);
`ifdef RS_OLDEST_FIRST_EN
          age[free_idx]  <= '0;
`endif
        end
        occupancy <= occupancy + CNT_W'(alloc) - CNT_W'(issue);
      end
    end
  end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// tb/tb_alu_rs_scheduler.sv - vector table, directed multi-cycle sequences and random run against a slot model
module tb_alu_rs_scheduler;
  localparam int RS_SIZE = 16;
  localparam int AGE_MAX = 2 * RS_SIZE - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_rs_scheduler_if #(.ROB_ID_WIDTH(4), .OP_ID_WIDTH(6)) bus ();
  alu_rs_scheduler #(.RS_SIZE(RS_SIZE), .ROB_ID_WIDTH(4), .OP_ID_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rdy = 1'b1; bus.clear = 1'b0; bus.DP_input_valid = 1'b0;
    bus.DP_OP_ID = '0; bus.DP_inst_pc = '0; bus.DP_Vj = '0; bus.DP_Vk = '0; bus.DP_imm = '0;
    bus.DP_Qj = '0; bus.DP_Qk = '0; bus.DP_ROB_id = '0; bus.DP_Qj_busy = 1'b0; bus.DP_Qk_busy = 1'b0;
    bus.ALU_CDB_valid = 1'b0; bus.ALU_CDB_ROB_id = '0; bus.ALU_CDB_value = '0;
    bus.LSB_CDB_valid = 1'b0; bus.LSB_CDB_ROB_id = '0; bus.LSB_CDB_value = '0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                      input logic [3:0] qj, input logic jb, input logic [3:0] qk, input logic kb,
                      input logic [31:0] imm, input logic [3:0] rob);
    bus.DP_input_valid = 1'b1; bus.DP_OP_ID = op; bus.DP_inst_pc = 32'h400 + 32'(rob);
    bus.DP_Vj = vj; bus.DP_Vk = vk; bus.DP_Qj = qj; bus.DP_Qj_busy = jb;
    bus.DP_Qk = qk; bus.DP_Qk_busy = kb; bus.DP_imm = imm; bus.DP_ROB_id = rob;
  endtask

  task automatic alu_cdb(input logic [3:0] tag, input logic [31:0] val);
    bus.ALU_CDB_valid = 1'b1; bus.ALU_CDB_ROB_id = tag; bus.ALU_CDB_value = val;
  endtask

  typedef struct {
    logic [5:0] op; logic [31:0] vj, vk, imm; logic [3:0] rob, qj, qk; logic jb, kb;
    logic av; logic [3:0] at; logic [31:0] aval;
    logic lv; logic [3:0] lt; logic [31:0] lval;
    logic ev; logic [31:0] e1, e2;
  } vec_t;
  vec_t vt [7];

  // Reference model: one record per slot, dispatch order tracked with a cycle stamp.
  typedef struct {
    logic busy; logic [5:0] op; logic [31:0] pc, vj, vk, imm;
    logic [3:0] qj, qk, rob; logic jb, kb; int stamp;
  } slot_t;
  slot_t m [RS_SIZE];
  logic e_valid, e_full;
  logic [5:0] e_op;
  logic [31:0] e_pc, e_rs1, e_rs2, e_imm;
  logic [3:0] e_rob;
  int tickc;

  task automatic resolve(inout logic b, input logic [3:0] t, inout logic [31:0] v);
    if (b && bus.ALU_CDB_valid && bus.ALU_CDB_ROB_id == t) begin b = 1'b0; v = bus.ALU_CDB_value; end
    else if (b && bus.LSB_CDB_valid && bus.LSB_CDB_ROB_id == t) begin b = 1'b0; v = bus.LSB_CDB_value; end
  endtask

`ifdef RS_OLDEST_FIRST_EN
  function automatic int age_of(input int i);
    int a;
    a = tickc - m[i].stamp - 1;
    return (a > AGE_MAX) ? AGE_MAX : a;
  endfunction
`endif

  task automatic model_reset();
    foreach (m[i]) m[i].busy = 1'b0;
    e_valid = 0; e_full = 0; e_op = '0; e_pc = '0; e_rs1 = '0; e_rs2 = '0; e_imm = '0; e_rob = '0;
    tickc = 0;
  endtask

  task automatic model_step();
    int sel, fr, cnt;
    logic b;
    logic [31:0] v;
    if (bus.rdy) begin
      if (bus.clear) begin
        foreach (m[i]) m[i].busy = 1'b0;
        e_valid = 1'b0;
      end else begin
        sel = -1; fr = -1;
        for (int i = 0; i < RS_SIZE; i++) begin
          if (m[i].busy && !m[i].jb && !m[i].kb) begin
`ifdef RS_OLDEST_FIRST_EN
            if (sel < 0 || age_of(i) > age_of(sel)) sel = i;
`else
            if (sel < 0) sel = i;
`endif
          end
          if (!m[i].busy && fr < 0) fr = i;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
          if (m[i].busy) begin
            b = m[i].jb; v = m[i].vj; resolve(b, m[i].qj, v); m[i].jb = b; m[i].vj = v;
            b = m[i].kb; v = m[i].vk; resolve(b, m[i].qk, v); m[i].kb = b; m[i].vk = v;
          end
        end
        e_valid = (sel >= 0);
        if (sel >= 0) begin
          e_op = m[sel].op; e_pc = m[sel].pc; e_rs1 = m[sel].vj; e_rs2 = m[sel].vk;
          e_imm = m[sel].imm; e_rob = m[sel].rob; m[sel].busy = 1'b0;
        end
        if (bus.DP_input_valid && fr >= 0) begin
          m[fr].busy = 1'b1; m[fr].op = bus.DP_OP_ID; m[fr].pc = bus.DP_inst_pc;
          m[fr].imm = bus.DP_imm; m[fr].rob = bus.DP_ROB_id; m[fr].qj = bus.DP_Qj; m[fr].qk = bus.DP_Qk;
          b = bus.DP_Qj_busy; v = bus.DP_Vj; resolve(b, bus.DP_Qj, v); m[fr].jb = b; m[fr].vj = v;
          b = bus.DP_Qk_busy; v = bus.DP_Vk; resolve(b, bus.DP_Qk, v); m[fr].kb = b; m[fr].vk = v;
          m[fr].stamp = tickc;
        end
      end
      tickc++;
    end
    cnt = 0;
    foreach (m[i]) if (m[i].busy) cnt++;
    e_full = (cnt >= RS_SIZE - 1);
  endtask

  initial begin
    logic [3:0] first_rob;
    vt[0] = '{op:6'h13, vj:5, vk:0, imm:3, rob:2, qj:0, qk:0, jb:0, kb:0,
              av:0, at:0, aval:0, lv:0, lt:0, lval:0, ev:1, e1:5, e2:0};
    vt[1] = '{op:6'h02, vj:1, vk:0, imm:0, rob:3, qj:0, qk:6, jb:0, kb:1,
              av:0, at:0, aval:0, lv:1, lt:6, lval:32'hDEADBEEF, ev:1, e1:1, e2:32'hDEADBEEF};
    vt[2] = '{op:6'h03, vj:0, vk:9, imm:7, rob:4, qj:3, qk:0, jb:1, kb:0,
              av:1, at:3, aval:32'h1234, lv:0, lt:0, lval:0, ev:1, e1:32'h1234, e2:9};
    vt[3] = '{op:6'h04, vj:0, vk:0, imm:1, rob:5, qj:3, qk:5, jb:1, kb:1,
              av:1, at:3, aval:32'hAA, lv:1, lt:5, lval:32'hBB, ev:1, e1:32'hAA, e2:32'hBB};
    vt[4] = '{op:6'h05, vj:0, vk:0, imm:0, rob:6, qj:7, qk:0, jb:1, kb:0,
              av:1, at:8, aval:32'h11, lv:0, lt:0, lval:0, ev:0, e1:0, e2:0};
    vt[5] = '{op:6'h06, vj:32'h55, vk:2, imm:0, rob:7, qj:4, qk:0, jb:0, kb:0,
              av:1, at:4, aval:32'h99, lv:0, lt:0, lval:0, ev:1, e1:32'h55, e2:2};
    vt[6] = '{op:6'h07, vj:0, vk:0, imm:9, rob:8, qj:2, qk:9, jb:1, kb:1,
              av:1, at:9, aval:32'h88, lv:1, lt:2, lval:32'h77, ev:1, e1:32'h77, e2:32'h88};

    rst = 1'b1; idle(); tick(); tick();
    chk("reset valid", 32'(bus.ALU_input_valid), 0);
    chk("reset full", 32'(bus.RS_full), 0);
    chk("reset op", 32'(bus.ALU_OP_ID), 0);
    chk("reset pc", bus.ALU_inst_pc, 0);
    chk("reset rs1", bus.ALU_reg_rs1, 0);
    chk("reset rs2", bus.ALU_reg_rs2, 0);
    chk("reset imm", bus.ALU_imm, 0);
    chk("reset rob", 32'(bus.ALU_ROB_id), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      disp(vt[i].op, vt[i].vj, vt[i].vk, vt[i].qj, vt[i].jb, vt[i].qk, vt[i].kb, vt[i].imm, vt[i].rob);
      bus.ALU_CDB_valid = vt[i].av; bus.ALU_CDB_ROB_id = vt[i].at; bus.ALU_CDB_value = vt[i].aval;
      bus.LSB_CDB_valid = vt[i].lv; bus.LSB_CDB_ROB_id = vt[i].lt; bus.LSB_CDB_value = vt[i].lval;
      tick(); idle();
      chk($sformatf("vec%0d no issue at dispatch edge", i), 32'(bus.ALU_input_valid), 0);
      tick();
      chk($sformatf("vec%0d valid", i), 32'(bus.ALU_input_valid), 32'(vt[i].ev));
      if (vt[i].ev) begin
        chk($sformatf("vec%0d rs1", i), bus.ALU_reg_rs1, vt[i].e1);
        chk($sformatf("vec%0d rs2", i), bus.ALU_reg_rs2, vt[i].e2);
        chk($sformatf("vec%0d op", i), 32'(bus.ALU_OP_ID), 32'(vt[i].op));
        chk($sformatf("vec%0d imm", i), bus.ALU_imm, vt[i].imm);
        chk($sformatf("vec%0d rob", i), 32'(bus.ALU_ROB_id), 32'(vt[i].rob));
        chk($sformatf("vec%0d pc", i), bus.ALU_inst_pc, 32'h400 + 32'(vt[i].rob));
      end else begin
        bus.clear = 1'b1; tick(); idle();
      end
      tick();
      chk($sformatf("vec%0d valid drops", i), 32'(bus.ALU_input_valid), 0);
    end

    // rdy low freezes the issue strobe
    disp(6'h13, 1, 1, 0, 0, 0, 0, 0, 6); tick(); idle(); tick();
    chk("rdy hold pre valid", 32'(bus.ALU_input_valid), 1);
    bus.rdy = 1'b0; tick();
    chk("rdy hold valid", 32'(bus.ALU_input_valid), 1);
    chk("rdy hold rob", 32'(bus.ALU_ROB_id), 6);
    bus.rdy = 1'b1; tick();
    chk("rdy release valid", 32'(bus.ALU_input_valid), 0);

    // wakeup from the ALU CDB, issue one cycle after the broadcast
    disp(6'h01, 0, 7, 4, 1, 0, 0, 0, 3); tick(); idle();
    chk("wakeup pending", 32'(bus.ALU_input_valid), 0);
    alu_cdb(4, 10); tick(); idle();
    chk("wakeup same cycle", 32'(bus.ALU_input_valid), 0);
    tick();
    chk("wakeup valid", 32'(bus.ALU_input_valid), 1);
    chk("wakeup rs1", bus.ALU_reg_rs1, 10);
    chk("wakeup rs2", bus.ALU_reg_rs2, 7);

    // A pending at index 0, B ready at index 1: B first, then A
    disp(6'h01, 0, 0, 1, 1, 0, 0, 0, 4); tick();
    disp(6'h01, 0, 0, 0, 0, 0, 0, 0, 5); tick(); idle(); tick();
    chk("order B first", 32'(bus.ALU_ROB_id), 5);
    alu_cdb(1, 32'h21); tick(); idle(); tick();
    chk("order A second", 32'(bus.ALU_ROB_id), 4);
    chk("order A valid", 32'(bus.ALU_input_valid), 1);

    // Q (older, index 1) and R (younger, index 0) woken together
    disp(6'h01, 0, 0, 7, 1, 0, 0, 0, 1); tick();
    disp(6'h01, 0, 0, 5, 1, 0, 0, 0, 2); tick(); idle();
    alu_cdb(7, 0); tick(); idle(); tick();
    chk("P issues", 32'(bus.ALU_ROB_id), 1);
    disp(6'h01, 0, 0, 5, 1, 0, 0, 0, 3); tick(); idle();
    alu_cdb(5, 0); tick(); idle(); tick();
`ifdef RS_OLDEST_FIRST_EN
    first_rob = 4'd2;
`else
    first_rob = 4'd3;
`endif
    chk("age order first", 32'(bus.ALU_ROB_id), 32'(first_rob));
    tick();
    chk("age order second", 32'(bus.ALU_ROB_id), 32'(first_rob == 4'd2 ? 4'd3 : 4'd2));
    chk("age order second valid", 32'(bus.ALU_input_valid), 1);
    tick();

    // fill with 15 blocked entries, then wake them all at once
    for (int i = 0; i < 15; i++) begin
      disp(6'(i), 0, 32'(i), 9, 1, 0, 0, 0, 4'(i)); tick();
      chk($sformatf("fill full %0d", i), 32'(bus.RS_full), (i >= 14) ? 1 : 0);
    end
    idle(); alu_cdb(9, 32'h900); tick(); idle();
    chk("fill woken no issue", 32'(bus.ALU_input_valid), 0);
    chk("fill still full", 32'(bus.RS_full), 1);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk($sformatf("drain valid %0d", k), 32'(bus.ALU_input_valid), 1);
      chk($sformatf("drain rob %0d", k), 32'(bus.ALU_ROB_id), k);
      chk($sformatf("drain rs2 %0d", k), bus.ALU_reg_rs2, k);
      chk($sformatf("drain full %0d", k), 32'(bus.RS_full), 0);
    end
    tick();
    chk("drain done", 32'(bus.ALU_input_valid), 0);

    // flush with a same-cycle dispatch
    for (int i = 0; i < 3; i++) begin
      disp(6'h01, 0, 0, 3, 1, 0, 0, 0, 4'(10 + i)); tick();
    end
    disp(6'h01, 1, 1, 0, 0, 0, 0, 0, 13); bus.clear = 1'b1; tick(); idle();
    chk("flush valid", 32'(bus.ALU_input_valid), 0);
    chk("flush full", 32'(bus.RS_full), 0);
    alu_cdb(3, 32'h33);
    for (int i = 0; i < 3; i++) begin
      tick(); idle();
      chk($sformatf("flush no issue %0d", i), 32'(bus.ALU_input_valid), 0);
    end
    for (int i = 0; i < 14; i++) begin
      disp(6'h01, 0, 0, 15, 1, 0, 0, 0, 1); tick();
    end
    idle();
    chk("flush occupancy cleared", 32'(bus.RS_full), 0);
    bus.clear = 1'b1; tick(); idle();

    // random traffic against the model
    rst = 1'b1; tick(); rst = 1'b0; model_reset();
    for (int c = 0; c < 3000 && nerr < 20; c++) begin
      bus.rdy = ($urandom_range(0, 9) != 0);
      bus.clear = ($urandom_range(0, 39) == 0);
      bus.DP_input_valid = 1'($urandom_range(0, 1));
      bus.DP_OP_ID = 6'($urandom); bus.DP_inst_pc = $urandom; bus.DP_imm = $urandom;
      bus.DP_Vj = $urandom; bus.DP_Vk = $urandom; bus.DP_ROB_id = 4'($urandom_range(0, 15));
      bus.DP_Qj = 4'($urandom_range(0, 7)); bus.DP_Qk = 4'($urandom_range(0, 7));
      bus.DP_Qj_busy = ($urandom_range(0, 2) == 0); bus.DP_Qk_busy = ($urandom_range(0, 2) == 0);
      bus.ALU_CDB_valid = 1'($urandom_range(0, 1)); bus.ALU_CDB_ROB_id = 4'($urandom_range(0, 7));
      bus.ALU_CDB_value = $urandom;
      bus.LSB_CDB_valid = 1'($urandom_range(0, 1)); bus.LSB_CDB_ROB_id = 4'($urandom_range(0, 7));
      bus.LSB_CDB_value = $urandom;
      if (bus.ALU_CDB_valid && bus.LSB_CDB_valid && bus.ALU_CDB_ROB_id == bus.LSB_CDB_ROB_id)
        bus.LSB_CDB_ROB_id = bus.LSB_CDB_ROB_id ^ 4'd1;
      model_step();
      tick();
      chk($sformatf("rand%0d valid", c), 32'(bus.ALU_input_valid), 32'(e_valid));
      chk($sformatf("rand%0d full", c), 32'(bus.RS_full), 32'(e_full));
      chk($sformatf("rand%0d op", c), 32'(bus.ALU_OP_ID), 32'(e_op));
      chk($sformatf("rand%0d pc", c), bus.ALU_inst_pc, e_pc);
      chk($sformatf("rand%0d rs1", c), bus.ALU_reg_rs1, e_rs1);
      chk($sformatf("rand%0d rs2", c), bus.ALU_reg_rs2, e_rs2);
      chk($sformatf("rand%0d imm", c), bus.ALU_imm, e_imm);
      chk($sformatf("rand%0d rob", c), 32'(bus.ALU_ROB_id), 32'(e_rob));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
